// File: rtl/lsq_mem_unit.sv
// lsq_mem_unit: memory-side consumer of the load/store queue.
// Takes the LSQ head once it is resolved, issues exactly one data-memory
// request for it, and reports the result (load data on the CDB, store
// completion to the ROB). Only one access is ever outstanding, and stores
// are sent to memory only when they sit at the ROB head.
//
// Handshake semantics (all interfaces):
//   - LSQ side: the head entry is offered while lsq_valid=1; it is taken
//     only when lsq_ready=1 (fields resolved), and the take is signalled by
//     a one-cycle combinational lsq_dequeue pulse in the same cycle as the
//     memory request. Younger entries are never bypassed.
//   - Memory side: a request is a one-cycle pulse on dmem_rmask/dmem_wmask
//     (non-zero mask = request). Exactly one dmem_resp pulse answers it at
//     least one cycle later; dmem_resp while no access is outstanding is
//     ignored.
//   - Result side: cdb_valid and store_done are registered one-cycle pulses
//     with their tags/data valid in the same cycle; there is no back-pressure.

module lsq_mem_unit #(
  parameter int DEPTH_BITS = 3,
  parameter int ROB_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  // LSQ head
  input  logic                  lsq_valid,
  input  logic                  lsq_ready,
  input  logic                  lsq_is_store,
  input  logic [2:0]            lsq_funct3,
  input  logic [31:0]           lsq_addr,
  input  logic [3:0]            lsq_mask,
  input  logic [31:0]           lsq_wdata,
  input  logic [ROB_BITS-1:0]   lsq_rob_id,
  output logic                  lsq_dequeue,
  // ROB head (store commit point)
  input  logic                  rob_head_valid,
  input  logic [ROB_BITS-1:0]   rob_head_id,
  // Data memory port
  output logic [31:0]           dmem_addr,
  output logic [3:0]            dmem_rmask,
  output logic [3:0]            dmem_wmask,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_resp,
  // Load broadcast
  output logic                  cdb_valid,
  output logic [ROB_BITS-1:0]   cdb_rob_id,
  output logic [31:0]           cdb_data,
  // Store completion
  output logic                  store_done,
  output logic [ROB_BITS-1:0]   store_rob_id,
  // Debug visibility: FSM state (1 = access outstanding) and a running
  // dequeue index that tracks the LSQ head pointer modulo its depth.
  output logic                  dbg_state,
  output logic [DEPTH_BITS-1:0] dbg_deq_idx
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [DEPTH_BITS-1:0] IDX_ONE = DEPTH_BITS'(1);

  // Load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_e                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [ROB_BITS-1:0]   rob_id_q, rob_id_d;
  logic                  kill_q, kill_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [ROB_BITS-1:0]   cdb_rob_id_q, cdb_rob_id_d;
  logic [31:0]           cdb_data_q, cdb_data_d;
  logic                  store_done_q, store_done_d;
  logic [ROB_BITS-1:0]   store_rob_id_q, store_rob_id_d;
  logic [DEPTH_BITS-1:0] deq_idx_q, deq_idx_d;

  logic                  store_at_head;
  logic                  issue;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_data;

  // Issue decision: oldest entry only, one access at a time, stores only at
  // ROB commit; flush and reset both block a new request in this cycle.
  always_comb begin
    store_at_head = rob_head_valid && (rob_head_id == lsq_rob_id);
    issue = (state_q == S_IDLE) && lsq_valid && lsq_ready && !flush && !rst &&
            (!lsq_is_store || store_at_head);
  end

  // Request outputs: masks are non-zero only in the issue cycle.
  always_comb begin
    lsq_dequeue = issue;
    dmem_addr   = {lsq_addr[31:2], 2'b00};
    dmem_rmask  = 4'b0000;
    dmem_wmask  = 4'b0000;
    dmem_wdata  = 32'h0000_0000;
    if (issue) begin
      if (lsq_is_store) begin
        dmem_wmask = lsq_mask;
        dmem_wdata = lsq_wdata;
      end else begin
        dmem_rmask = lsq_mask;
      end
    end
  end

  // Lane selection for sub-word loads using the latched byte offset.
  always_comb begin
    ld_byte = 8'h00;
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  end

  // Width/sign extension of the returned word; unknown codes return zero.
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3_q)
      F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data = {24'h000000, ld_byte};
      F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  load_data = {16'h0000, ld_half};
      F3_LW:   load_data = dmem_rdata;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // FSM next state, request latching, kill tracking and result pulses.
  always_comb begin
    state_d        = state_q;
    is_store_d     = is_store_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    rob_id_d       = rob_id_q;
    kill_d         = kill_q;
    cdb_valid_d    = 1'b0;
    cdb_rob_id_d   = cdb_rob_id_q;
    cdb_data_d     = cdb_data_q;
    store_done_d   = 1'b0;
    store_rob_id_d = store_rob_id_q;
    deq_idx_d      = issue ? (deq_idx_q + IDX_ONE) : deq_idx_q;

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (issue) begin
          state_d    = S_WAIT;
          is_store_d = lsq_is_store;
          funct3_d   = lsq_funct3;
          off_d      = lsq_addr[1:0];
          rob_id_d   = lsq_rob_id;
        end
      end
      S_WAIT: begin
        // A flushed load must still drain its response before the unit is
        // free again; committed stores are unaffected by flush.
        if (flush && !is_store_q) begin
          kill_d = 1'b1;
        end
        if (dmem_resp) begin
          state_d = S_IDLE;
          kill_d  = 1'b0;
          if (is_store_q) begin
            store_done_d   = 1'b1;
            store_rob_id_d = rob_id_q;
          end else if (!kill_q && !flush) begin
            cdb_valid_d  = 1'b1;
            cdb_rob_id_d = rob_id_q;
            cdb_data_d   = load_data;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; an outstanding access is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      off_q          <= 2'b00;
      rob_id_q       <= '0;
      kill_q         <= 1'b0;
      cdb_valid_q    <= 1'b0;
      cdb_rob_id_q   <= '0;
      cdb_data_q     <= 32'h0000_0000;
      store_done_q   <= 1'b0;
      store_rob_id_q <= '0;
      deq_idx_q      <= '0;
    end else begin
      state_q        <= state_d;
      is_store_q     <= is_store_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
      rob_id_q       <= rob_id_d;
      kill_q         <= kill_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_rob_id_q   <= cdb_rob_id_d;
      cdb_data_q     <= cdb_data_d;
      store_done_q   <= store_done_d;
      store_rob_id_q <= store_rob_id_d;
      deq_idx_q      <= deq_idx_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rob_id   = cdb_rob_id_q;
  assign cdb_data     = cdb_data_q;
  assign store_done   = store_done_q;
  assign store_rob_id = store_rob_id_q;
  assign dbg_state    = (state_q == S_WAIT);
  assign dbg_deq_idx  = deq_idx_q;

endmodule

// File: tb/tb_lsq_mem_unit.sv
// Testbench for lsq_mem_unit: a transaction-level LSQ/ROB/memory model
// drives the unit and predicts, cycle by cycle, which requests it must
// issue and which results it must report.

module tb_lsq_mem_unit;

  localparam int DB = 3;
  localparam int RB = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush;
  logic          lsq_valid, lsq_ready, lsq_is_store;
  logic [2:0]    lsq_funct3;
  logic [31:0]   lsq_addr, lsq_wdata;
  logic [3:0]    lsq_mask;
  logic [RB-1:0] lsq_rob_id;
  logic          lsq_dequeue;
  logic          rob_head_valid;
  logic [RB-1:0] rob_head_id;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]    dmem_rmask, dmem_wmask;
  logic          dmem_resp;
  logic          cdb_valid;
  logic [RB-1:0] cdb_rob_id;
  logic [31:0]   cdb_data;
  logic          store_done;
  logic [RB-1:0] store_rob_id;
  logic          dbg_state;
  logic [DB-1:0] dbg_deq_idx;

  lsq_mem_unit #(.DEPTH_BITS(DB), .ROB_BITS(RB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lsq_valid(lsq_valid), .lsq_ready(lsq_ready), .lsq_is_store(lsq_is_store),
    .lsq_funct3(lsq_funct3), .lsq_addr(lsq_addr), .lsq_mask(lsq_mask),
    .lsq_wdata(lsq_wdata), .lsq_rob_id(lsq_rob_id), .lsq_dequeue(lsq_dequeue),
    .rob_head_valid(rob_head_valid), .rob_head_id(rob_head_id),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .store_done(store_done), .store_rob_id(store_rob_id),
    .dbg_state(dbg_state), .dbg_deq_idx(dbg_deq_idx)
  );

  typedef struct {
    bit            is_store;
    logic [2:0]    f3;
    logic [31:0]   addr;
    logic [3:0]    mask;
    logic [31:0]   wdata;
    logic [RB-1:0] rob;
  } entry_t;

  // Scoreboard state
  entry_t            txn_q[$];
  logic [RB+31:0]    exp_q[$];
  logic [RB-1:0]     sd_q[$];
  logic [31:0]       mem [0:63];
  int                n_checks = 0;
  int                n_errors = 0;

  // Model of the single outstanding access
  bit      busy = 0;
  bit      killed = 0;
  entry_t  pend;
  int      cnt = 0;
  logic [DB-1:0] deq_idx_m = '0;

  // Stimulus knobs
  int ready_pct = 100, flush_pct = 0, dly_min = 1, dly_max = 1;
  int rob_match_pct = 0, idle_resp_pct = 0;
  bit rob_ovr = 1'b1;
  logic rob_ovr_v = 1'b0;
  logic [RB-1:0] rob_ovr_id = '0;
  bit flush_once = 1'b0;

  // Observation counters
  int n_deq = 0, n_cdb = 0, n_sd = 0;
  logic [31:0] last_cdb_data = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // Reference load result from the returned word, by plain shifts and casts.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sb, sh;
    byte b;
    shortint h;
    sb = w >> (8 * off);
    sh = w >> (16 * off[1]);
    b = sb[7:0];
    h = sh[15:0];
    case (f3)
      3'd0:    return 32'(int'(b));
      3'd4:    return sb & 32'h0000_00FF;
      3'd1:    return 32'(int'(h));
      3'd5:    return sh & 32'h0000_FFFF;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic entry_t mk(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] data, input logic [RB-1:0] rob);
    entry_t e;
    e.is_store = st;
    e.f3 = f3;
    e.addr = addr;
    e.rob = rob;
    case (f3[1:0])
      2'd0:    e.mask = 4'b0001 << addr[1:0];
      2'd1:    e.mask = 4'b0011 << {addr[1], 1'b0};
      default: e.mask = 4'b1111;
    endcase
    e.wdata = data << (8 * addr[1:0]);
    return e;
  endfunction

  // Driver + checker for one clock cycle.
  task automatic step(input bit do_rst);
    entry_t hd;
    bit have, issue, resp_now;
    logic [RB+31:0] e;
    logic [RB-1:0] sr;
    @(negedge clk);
    rst = do_rst;
    have = (txn_q.size() > 0);
    if (have) hd = txn_q[0];
    else begin
      hd.is_store = 1'($urandom_range(0, 1));
      hd.f3 = 3'($urandom_range(0, 7));
      hd.addr = $urandom();
      hd.mask = 4'($urandom_range(0, 15));
      hd.wdata = $urandom();
      hd.rob = RB'($urandom_range(0, 15));
    end
    lsq_valid    = have;
    lsq_ready    = ($urandom_range(0, 99) < ready_pct);
    lsq_is_store = hd.is_store;
    lsq_funct3   = hd.f3;
    lsq_addr     = hd.addr;
    lsq_mask     = hd.mask;
    lsq_wdata    = hd.wdata;
    lsq_rob_id   = hd.rob;
    if (rob_ovr) begin
      rob_head_valid = rob_ovr_v;
      rob_head_id    = rob_ovr_id;
    end else if (have && hd.is_store && $urandom_range(0, 99) < rob_match_pct) begin
      rob_head_valid = 1'b1;
      rob_head_id    = hd.rob;
    end else begin
      rob_head_valid = 1'($urandom_range(0, 1));
      rob_head_id    = RB'($urandom_range(0, 15));
    end
    flush = flush_once || ($urandom_range(0, 99) < flush_pct);
    flush_once = 1'b0;
    resp_now = 1'b0;
    if (busy) begin
      cnt--;
      if (cnt == 0) resp_now = 1'b1;
      dmem_resp = resp_now;
    end else begin
      dmem_resp = ($urandom_range(0, 99) < idle_resp_pct);
    end
    dmem_rdata = (busy && !pend.is_store) ? mem[widx(pend.addr)] : $urandom();
    #1;
    // Registered results predicted in the previous cycle
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cdb_valid", cdb_valid, 1);
      chk("cdb_rob_id", cdb_rob_id, e[RB+31:32]);
      chk("cdb_data", cdb_data, e[31:0]);
    end else begin
      chk("cdb_valid_quiet", cdb_valid, 0);
    end
    if (sd_q.size() > 0) begin
      sr = sd_q.pop_front();
      chk("store_done", store_done, 1);
      chk("store_rob_id", store_rob_id, sr);
    end else begin
      chk("store_done_quiet", store_done, 0);
    end
    if (cdb_valid === 1'b1) begin n_cdb++; last_cdb_data = cdb_data; end
    if (store_done === 1'b1) n_sd++;
    chk("dbg_state", dbg_state, busy);
    chk("dbg_deq_idx", dbg_deq_idx, deq_idx_m);
    // Requests expected in this cycle
    issue = !do_rst && !busy && have && lsq_ready && !flush &&
            (!hd.is_store || (rob_head_valid && rob_head_id == hd.rob));
    chk("lsq_dequeue", lsq_dequeue, issue);
    chk("dmem_rmask", dmem_rmask, (issue && !hd.is_store) ? hd.mask : 4'b0);
    chk("dmem_wmask", dmem_wmask, (issue && hd.is_store) ? hd.mask : 4'b0);
    if (issue) chk("dmem_addr", dmem_addr, hd.addr & 32'hFFFF_FFFC);
    if (issue && hd.is_store) chk("dmem_wdata", dmem_wdata, hd.wdata);
    if (lsq_dequeue === 1'b1) n_deq++;
    // Model update
    if (do_rst) begin
      busy = 0;
      killed = 0;
      deq_idx_m = '0;
    end else begin
      if (busy && resp_now) begin
        if (pend.is_store) begin
          for (int i = 0; i < 4; i++)
            if (pend.mask[i]) mem[widx(pend.addr)][8*i +: 8] = pend.wdata[8*i +: 8];
          sd_q.push_back(pend.rob);
        end else if (!(killed || flush)) begin
          exp_q.push_back({pend.rob, ref_load(pend.f3, pend.addr[1:0], dmem_rdata)});
        end
        busy = 0;
      end else if (busy && flush && !pend.is_store) begin
        killed = 1;
      end
      if (issue) begin
        busy = 1;
        killed = 0;
        pend = hd;
        void'(txn_q.pop_front());
        cnt = $urandom_range(dly_min, dly_max);
        deq_idx_m = deq_idx_m + 1'b1;
      end
    end
  endtask

  task automatic run_idle(input int max_cyc);
    int i;
    i = 0;
    while ((txn_q.size() > 0 || busy || exp_q.size() > 0 || sd_q.size() > 0) && i < max_cyc) begin
      step(1'b0);
      i++;
    end
    if (i >= max_cyc) begin
      chk("run_timeout", 1, 0);
      txn_q.delete();
      exp_q.delete();
      sd_q.delete();
    end
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_cdb_valid"}, cdb_valid, 0);
    chk({tag, "_cdb_rob_id"}, cdb_rob_id, 0);
    chk({tag, "_cdb_data"}, cdb_data, 0);
    chk({tag, "_store_done"}, store_done, 0);
    chk({tag, "_store_rob_id"}, store_rob_id, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int d0, c0;
    logic [2:0] f3;
    logic [31:0] a;
    bit st;
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    flush = 0; lsq_valid = 0; lsq_ready = 0; lsq_is_store = 0; lsq_funct3 = 0;
    lsq_addr = 0; lsq_mask = 0; lsq_wdata = 0; lsq_rob_id = 0;
    rob_head_valid = 0; rob_head_id = 0; dmem_rdata = 0; dmem_resp = 0;
    repeat (3) @(posedge clk);

    // Reset state, and no request while reset is held even with a ready head
    @(negedge clk);
    lsq_valid = 1; lsq_ready = 1; lsq_mask = 4'hF; lsq_addr = 32'h1000;
    #1;
    chk_regs_zero("reset");
    chk("reset_dequeue", lsq_dequeue, 0);
    chk("reset_rmask", dmem_rmask, 0);
    chk("reset_wmask", dmem_wmask, 0);

    // LW with two-cycle response
    mem[widx(32'h1000)] = 32'hDEAD_BEEF;
    dly_min = 2; dly_max = 2;
    c0 = n_cdb;
    txn_q.push_back(mk(0, 3'd2, 32'h1000, 0, 4'd7));
    run_idle(50);
    chk("lw_data", last_cdb_data, 32'hDEAD_BEEF);
    chk("lw_count", n_cdb - c0, 1);

    // Sub-word loads
    mem[widx(32'h1000)] = 32'h80A5_C3E1;
    txn_q.push_back(mk(0, 3'd0, 32'h1003, 0, 4'd1));
    run_idle(50);
    chk("lb_data", last_cdb_data, 32'hFFFF_FF80);
    txn_q.push_back(mk(0, 3'd4, 32'h1003, 0, 4'd2));
    run_idle(50);
    chk("lbu_data", last_cdb_data, 32'h0000_0080);
    mem[widx(32'h1000)] = 32'h8001_C3E1;
    txn_q.push_back(mk(0, 3'd1, 32'h1002, 0, 4'd3));
    run_idle(50);
    chk("lh_data", last_cdb_data, 32'hFFFF_8001);

    // Store waits for ROB head
    d0 = n_deq; c0 = n_sd;
    rob_ovr_v = 1; rob_ovr_id = 4'd3;
    txn_q.push_back(mk(1, 3'd2, 32'h1010, 32'h1234_5678, 4'd5));
    repeat (4) step(1'b0);
    chk("store_stall_deq", n_deq - d0, 0);
    rob_ovr_id = 4'd5;
    run_idle(50);
    chk("store_deq", n_deq - d0, 1);
    chk("store_done_count", n_sd - c0, 1);
    rob_ovr_v = 0;

    // Flush during a load's wait: no broadcast, next load proceeds
    dly_min = 3; dly_max = 3;
    c0 = n_cdb;
    txn_q.push_back(mk(0, 3'd2, 32'h1004, 0, 4'd2));
    step(1'b0);
    flush_once = 1;
    run_idle(50);
    chk("flush_no_cdb", n_cdb - c0, 0);
    txn_q.push_back(mk(0, 3'd2, 32'h1008, 0, 4'd9));
    run_idle(50);
    chk("after_flush_cdb", n_cdb - c0, 1);

    // Reset while waiting; late/stray responses are ignored
    dly_min = 5; dly_max = 5;
    c0 = n_cdb;
    txn_q.push_back(mk(0, 3'd2, 32'h100C, 0, 4'd4));
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    idle_resp_pct = 100;
    repeat (4) step(1'b0);
    idle_resp_pct = 0;
    chk("rst_no_cdb", n_cdb - c0, 0);
    chk_regs_zero("post_rst");

    // Back-to-back loads, one-cycle response
    dly_min = 1; dly_max = 1;
    d0 = n_deq; c0 = n_cdb;
    txn_q.push_back(mk(0, 3'd2, 32'h1014, 0, 4'd10));
    txn_q.push_back(mk(0, 3'd5, 32'h1016, 0, 4'd11));
    run_idle(50);
    chk("b2b_deq", n_deq - d0, 2);
    chk("b2b_cdb", n_cdb - c0, 2);

    // Randomized mix
    ready_pct = 70; flush_pct = 5; dly_min = 1; dly_max = 4;
    rob_ovr = 0; rob_match_pct = 40; idle_resp_pct = 20;
    for (int n = 0; n < 120; n++) begin
      st = ($urandom_range(0, 2) == 0);
      if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 9))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4; 3: f3 = 3'd5;
          4: f3 = 3'd3; 5: f3 = 3'd6; 6: f3 = 3'd7;
          default: f3 = 3'd2;
        endcase
      end
      a = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      case (f3[1:0])
        2'd0: a = a + 32'($urandom_range(0, 3));
        2'd1: a = a + 32'($urandom_range(0, 1) * 2);
        default: a = a;
      endcase
      txn_q.push_back(mk(st, f3, a, $urandom(), RB'($urandom_range(0, 15))));
    end
    run_idle(5000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
